kf8237_priority_sequencer: RTL and testbench
============================================

KF8237_PRIORITY_SEQUENCER -- requirements
Module: kf8237_priority_sequencer

Interface
REQ-001 SHALL have no parameters; the channel count is fixed at 4.
REQ-002 clock  in  1  system clock; all state updates on the falling edge, consistent with the register file.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 master_clear  in  1  synchronous software clear; same effect as reset.
REQ-005 dreq  in  4  per-channel active-high DMA requests, already synchronised.
REQ-006 channel_mask  in  4  1 = channel not eligible.
REQ-007 controller_disable  in  1  1 = no new arbitration.
REQ-008 rotating_priority_config  in  1  1 = rotating priority, 0 = fixed priority.
REQ-009 autoinit_config  in  4  per-channel auto-initialize enable.
REQ-010 hlda  in  1  hold acknowledge from CPU.
REQ-011 eop_n_in  in  1  external end-of-process, active-low.
REQ-012 underflow  in  1  word-count underflow from the address/count registers; valid while next_word=1.
REQ-013 clear_terminal_count  in  1  status-read pulse; clears all terminal_count bits.
REQ-014 hrq  out  1  hold request.
REQ-015 dack  out  4  one-hot DMA acknowledge, active-high.
REQ-016 transfer_register_select  out  4  one-hot channel select to the address/count registers.
REQ-017 next_word  out  1  one-cycle advance strobe to the address/count registers.
REQ-018 initialize_current_register  out  1  one-cycle reload strobe to the address/count registers.
REQ-019 terminal_count  out  4  sticky per-channel TC status.
REQ-020 end_of_process  out  1  one-cycle TC/EOP pulse.
REQ-021 set_mask  out  4  one-cycle request to set the serviced channel's mask bit.

Function
REQ-022 eligible = dreq & ~channel_mask, all zero when controller_disable=1.
REQ-023 FSM states SHALL be SI, S0, S1, S2, S3, S4, operating in single-transfer mode: one transfer per grant.
REQ-024 SI, eligible != 0: latch the winner one-hot into transfer_register_select, set hrq=1, go to S0.
REQ-025 SI, eligible == 0: remain in SI.
REQ-026 S0: hrq=1; on hlda=1 go to S1.
REQ-027 S0: if the winner's dreq drops before hlda=1, clear hrq and the select, and return to SI with no transfer.
REQ-028 S1–S4: dack equals transfer_register_select.
REQ-029 S1–S4: hlda, dreq and mask changes are ignored until S4 completes.
REQ-030 Transitions SHALL be S1 -> S2 -> S3 -> S4, one clock each.
REQ-031 S4: next_word=1 for exactly one cycle.
REQ-032 S4: tc_event = underflow | ~eop_n_in, sampled in S4.
REQ-033 On tc_event, S4 SHALL set terminal_count[ch] and pulse end_of_process.
REQ-034 On tc_event with autoinit_config[ch]=1: pulse initialize_current_register in the following SI cycle, with the select still held.
REQ-035 On tc_event with autoinit_config[ch]=0: pulse set_mask[ch] in the following SI cycle.
REQ-036 S4 -> SI: hrq and dack deassert on entry to SI.
REQ-037 On S4 -> SI, the select clears one cycle after SI entry (after any init strobe).
REQ-038 After S4, SI SHALL NOT re-arbitrate in the same cycle as the init/mask strobe; the earliest new hrq is 2 cycles after S4.
REQ-039 Fixed priority: ch0 highest, ch3 lowest.
REQ-040 Rotating priority: after servicing ch n, ch (n+1) mod 4 becomes highest; the pointer updates only on S4 exit.
REQ-041 In S4, if clear_terminal_count and tc_event coincide, the set wins for the serviced channel; other channels clear.
REQ-042 master_clear in any state SHALL return to SI with all outputs low, including mid-transfer.
REQ-043 No arithmetic; the priority pointer is 2 bits and wraps 3 -> 0.

Reset
REQ-044 On reset_n=0, immediately: state=SI, hrq=0, dack=0, transfer_register_select=0, next_word=0, initialize_current_register=0, terminal_count=0, end_of_process=0, set_mask=0, priority pointer=ch0.
REQ-045 On reset_n deassertion, the first possible hrq is on the first falling edge with eligible != 0.

Configuration
REQ-046 Macro KF8237_ROTATING_PRIORITY_EN.
REQ-047 With KF8237_ROTATING_PRIORITY_EN defined: rotating_priority_config selects the mode per REQ-040.
REQ-048 Without KF8237_ROTATING_PRIORITY_EN: the pointer logic is absent, rotating_priority_config is ignored, and priority is always fixed.

Verification
REQ-049 dreq=4'b1010, mask=0, fixed -> hrq; hlda=1 -> dack=4'b0010 for S1–S4; next_word pulses once in S4.
REQ-050 dreq=4'b0100, underflow=1 in S4, autoinit[2]=1 -> terminal_count=4'b0100, end_of_process pulse, initialize_current_register pulse next cycle with select=4'b0100.
REQ-051 Same as REQ-050 with autoinit[2]=0 -> set_mask=4'b0100 pulse; no init strobe.
REQ-052 Rotating mode, dreq=4'b1111 held -> grants in order ch0, ch1, ch2, ch3, ch0.
REQ-053 dreq[1] drops while in S0 -> hrq falls; no dack; state SI.
REQ-054 reset_n=0 during S2 -> all outputs 0 immediately; after release with dreq=4'b0001, the normal sequence restarts.

Source files
------------

// File: rtl/kf8237_priority_sequencer.sv
// kf8237_priority_sequencer: 4-channel 8237-style request arbiter and single-transfer sequencer.
// Define KF8237_ROTATING_PRIORITY_EN to build the rotating-priority pointer; otherwise fixed priority.
module kf8237_priority_sequencer (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       master_clear,
   input  logic [3:0] dreq,
   input  logic [3:0] channel_mask,
   input  logic       controller_disable,
   input  logic       rotating_priority_config,
   input  logic [3:0] autoinit_config,
   input  logic       hlda,
   input  logic       eop_n_in,
   input  logic       underflow,
   input  logic       clear_terminal_count,
   output logic       hrq,
   output logic [3:0] dack,
   output logic [3:0] transfer_register_select,
   output logic       next_word,
   output logic       initialize_current_register,
   output logic [3:0] terminal_count,
   output logic       end_of_process,
   output logic [3:0] set_mask
);

   typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4} state_t;

   state_t     state_q, state_d;
   logic [3:0] sel_q, sel_d;
   logic [3:0] tc_q, tc_d;
   logic [3:0] set_mask_q, set_mask_d;
   logic       init_q, init_d;
   logic       post_q, post_d;
   logic [3:0] eligible;
   logic [3:0] winner;
   logic       tc_event;

   assign eligible = controller_disable ? 4'b0000 : (dreq & ~channel_mask);
   assign tc_event = underflow | ~eop_n_in;

   function automatic logic [3:0] first_one(input logic [3:0] v);
      logic [3:0] r;
      if (v[0])      r = 4'b0001;
      else if (v[1]) r = 4'b0010;
      else if (v[2]) r = 4'b0100;
      else if (v[3]) r = 4'b1000;
      else           r = 4'b0000;
      return r;
   endfunction

`ifdef KF8237_ROTATING_PRIORITY_EN
   logic [1:0] ptr_q, ptr_d;
   logic [1:0] base;
   logic [3:0] rot;
   logic [3:0] pick;

   assign base = rotating_priority_config ? ptr_q : 2'd0;

   // Rotate so the highest-priority channel sits at bit 0, pick, then rotate back.
   always_comb begin
      case (base)
         2'd0:    rot = eligible;
         2'd1:    rot = {eligible[0],   eligible[3:1]};
         2'd2:    rot = {eligible[1:0], eligible[3:2]};
         default: rot = {eligible[2:0], eligible[3]};
      endcase
      pick = first_one(rot);
      case (base)
         2'd0:    winner = pick;
         2'd1:    winner = {pick[2:0], pick[3]};
         2'd2:    winner = {pick[1:0], pick[3:2]};
         default: winner = {pick[0],   pick[3:1]};
      endcase
   end

   always_comb begin
      ptr_d = ptr_q;
      if (state_q == S4 && rotating_priority_config) begin
         case (sel_q)
            4'b0001: ptr_d = 2'd1;
            4'b0010: ptr_d = 2'd2;
            4'b0100: ptr_d = 2'd3;
            default: ptr_d = 2'd0;
         endcase
      end
      if (master_clear) ptr_d = 2'd0;
   end

   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) ptr_q <= 2'd0;
      else          ptr_q <= ptr_d;
   end
`else
   logic unused_rot_cfg;
   assign unused_rot_cfg = rotating_priority_config;
   assign winner         = first_one(eligible);
`endif

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      tc_d       = clear_terminal_count ? 4'b0000 : tc_q;
      init_d     = 1'b0;
      set_mask_d = 4'b0000;
      post_d     = 1'b0;
      case (state_q)
         SI: begin
            // The cycle after S4 only carries the strobes and drops the select.
            if (post_q) begin
               sel_d = 4'b0000;
            end else if (eligible != 4'b0000) begin
               sel_d   = winner;
               state_d = S0;
            end
         end
         S0: begin
            if ((dreq & sel_q) == 4'b0000) begin
               sel_d   = 4'b0000;
               state_d = SI;
            end else if (hlda) begin
               state_d = S1;
            end
         end
         S1: state_d = S2;
         S2: state_d = S3;
         S3: state_d = S4;
         S4: begin
            state_d = SI;
            post_d  = 1'b1;
            if (tc_event) begin
               tc_d = tc_d | sel_q;
               if ((autoinit_config & sel_q) != 4'b0000) init_d = 1'b1;
               else                                      set_mask_d = sel_q;
            end
         end
         default: begin
            state_d = SI;
            sel_d   = 4'b0000;
         end
      endcase
      if (master_clear) begin
         state_d    = SI;
         sel_d      = 4'b0000;
         tc_d       = 4'b0000;
         init_d     = 1'b0;
         set_mask_d = 4'b0000;
         post_d     = 1'b0;
      end
   end

   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= SI;
         sel_q      <= 4'b0000;
         tc_q       <= 4'b0000;
         init_q     <= 1'b0;
         set_mask_q <= 4'b0000;
         post_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         tc_q       <= tc_d;
         init_q     <= init_d;
         set_mask_q <= set_mask_d;
         post_q     <= post_d;
      end
   end

   assign hrq                         = (state_q != SI);
   assign dack                        = (state_q == S1 || state_q == S2 ||
                                         state_q == S3 || state_q == S4) ? sel_q : 4'b0000;
   assign transfer_register_select    = sel_q;
   assign next_word                   = (state_q == S4);
   assign end_of_process              = (state_q == S4) & tc_event;
   assign initialize_current_register = init_q;
   assign set_mask                    = set_mask_q;
   assign terminal_count              = tc_q;

endmodule

// File: tb/tb_kf8237_priority_sequencer.sv
// Directed and randomized bench for kf8237_priority_sequencer against a phase-level reference model.
module tb_kf8237_priority_sequencer;

`ifdef KF8237_ROTATING_PRIORITY_EN
   localparam bit ROT_EN = 1'b1;
`else
   localparam bit ROT_EN = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset_n, master_clear, controller_disable, rotating_priority_config;
   logic       hlda, eop_n_in, underflow, clear_terminal_count;
   logic [3:0] dreq, channel_mask, autoinit_config;
   logic       hrq, next_word, initialize_current_register, end_of_process;
   logic [3:0] dack, transfer_register_select, terminal_count, set_mask;

   int tests = 0;
   int fails = 0;

   // Reference model: phase 0 idle, 1 waiting for hlda, 2..5 the four transfer
   // cycles, 6 the strobe cycle after the transfer.
   int       phase, ch, ptr;
   bit [3:0] mtc;
   bit       pend_init, pend_mask;

   kf8237_priority_sequencer dut (
      .clock(clock), .reset_n(reset_n), .master_clear(master_clear), .dreq(dreq),
      .channel_mask(channel_mask), .controller_disable(controller_disable),
      .rotating_priority_config(rotating_priority_config), .autoinit_config(autoinit_config),
      .hlda(hlda), .eop_n_in(eop_n_in), .underflow(underflow),
      .clear_terminal_count(clear_terminal_count), .hrq(hrq), .dack(dack),
      .transfer_register_select(transfer_register_select), .next_word(next_word),
      .initialize_current_register(initialize_current_register),
      .terminal_count(terminal_count), .end_of_process(end_of_process), .set_mask(set_mask));

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      phase = 0; ch = -1; ptr = 0; mtc = 4'b0000; pend_init = 0; pend_mask = 0;
   endtask

   task automatic model_step();
      bit [3:0] elig, ntc;
      bit       ev, found;
      int       base, c;
      ev = underflow || !eop_n_in;
      if (!reset_n || master_clear) begin
         model_reset();
         return;
      end
      ntc = clear_terminal_count ? 4'b0000 : mtc;
      case (phase)
         0: begin
            elig = controller_disable ? 4'b0000 : (dreq & ~channel_mask);
            base = (ROT_EN && rotating_priority_config) ? ptr : 0;
            found = 0;
            for (int i = 0; i < 4; i++) begin
               c = (base + i) % 4;
               if (!found && elig[c]) begin ch = c; found = 1; end
            end
            if (found) phase = 1;
         end
         1: begin
            if (!dreq[ch])  begin phase = 0; ch = -1; end
            else if (hlda)  phase = 2;
         end
         2, 3, 4: phase = phase + 1;
         5: begin
            pend_init = ev && autoinit_config[ch];
            pend_mask = ev && !autoinit_config[ch];
            if (ev) ntc[ch] = 1'b1;
            if (ROT_EN && rotating_priority_config) ptr = (ch + 1) % 4;
            phase = 6;
         end
         default: begin
            phase = 0; ch = -1; pend_init = 0; pend_mask = 0;
         end
      endcase
      mtc = ntc;
   endtask

   // Compare all outputs mid-cycle (rising edge), then advance the model over the falling edge.
   task automatic tick();
      logic [3:0] chbit;
      bit         ev;
      @(posedge clock);
      ev    = underflow || !eop_n_in;
      chbit = (ch >= 0) ? (4'b0001 << ch) : 4'b0000;
      chk("hrq",  {3'b0, hrq},       {3'b0, (phase >= 1 && phase <= 5)});
      chk("dack", dack,              (phase >= 2 && phase <= 5) ? chbit : 4'b0000);
      chk("sel",  transfer_register_select, (phase >= 1) ? chbit : 4'b0000);
      chk("next_word", {3'b0, next_word}, {3'b0, (phase == 5)});
      chk("eop",  {3'b0, end_of_process}, {3'b0, (phase == 5 && ev)});
      chk("init", {3'b0, initialize_current_register}, {3'b0, (phase == 6 && pend_init)});
      chk("set_mask", set_mask, (phase == 6 && pend_mask) ? chbit : 4'b0000);
      chk("tc",   terminal_count, mtc);
      model_step();
      @(negedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      master_clear = 0; dreq = 4'b0000; channel_mask = 4'b0000; controller_disable = 0;
      rotating_priority_config = 0; autoinit_config = 4'b0000; hlda = 0; eop_n_in = 1;
      underflow = 0; clear_terminal_count = 0;
   endtask

   initial begin
      reset_n = 0;
      idle_inputs();
      model_reset();
      tick(); tick();
      reset_n = 1;
      tick();

      // Fixed priority: ch1 wins over ch3; full single transfer with hlda.
      dreq = 4'b1010;
      tick(); tick();
      hlda = 1;
      for (int i = 0; i < 4; i++) begin
         chk("dack_ch1", dack, (phase >= 2) ? 4'b0010 : 4'b0000);
         tick();
      end
      dreq = 4'b0000;
      for (int i = 0; i < 6; i++) tick();

      // Underflow in S4 with autoinit on ch2, then with autoinit off.
      dreq = 4'b0100; autoinit_config = 4'b0100; underflow = 1;
      for (int i = 0; i < 8; i++) tick();
      chk("tc_ch2", terminal_count, 4'b0100);
      dreq = 4'b0000;
      clear_terminal_count = 1; tick(); clear_terminal_count = 0;
      tick(); tick();
      dreq = 4'b0100; autoinit_config = 4'b0000;
      for (int i = 0; i < 8; i++) tick();
      dreq = 4'b0000; underflow = 0;
      for (int i = 0; i < 3; i++) tick();

      // Coincident clear and TC: serviced channel's set wins, others clear.
      dreq = 4'b0010; eop_n_in = 0;
      for (int i = 0; i < 10; i++) begin
         clear_terminal_count = (phase == 5);
         tick();
      end
      clear_terminal_count = 0; eop_n_in = 1; dreq = 4'b0000;
      tick(); tick();

      // Rotating priority with all requests held.
      rotating_priority_config = 1; dreq = 4'b1111; hlda = 1;
      for (int i = 0; i < 40; i++) tick();
      rotating_priority_config = 0; dreq = 4'b0000; hlda = 0;
      for (int i = 0; i < 4; i++) tick();

      // Request withdrawn while waiting for hlda.
      dreq = 4'b0010;
      tick(); tick();
      dreq = 4'b0000;
      tick(); tick();
      chk("drop_hrq", {3'b0, hrq}, 4'b0000);

      // Asynchronous reset in the middle of a transfer.
      dreq = 4'b0001; hlda = 1;
      for (int i = 0; i < 10 && phase != 3; i++) tick();
      reset_n = 0;
      #1;
      chk("rst_hrq",  {3'b0, hrq}, 4'b0000);
      chk("rst_dack", dack, 4'b0000);
      chk("rst_sel",  transfer_register_select, 4'b0000);
      chk("rst_nw",   {3'b0, next_word}, 4'b0000);
      model_reset();
      tick();
      reset_n = 1;
      for (int i = 0; i < 10; i++) tick();
      idle_inputs();
      tick(); tick();

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         dreq                     = 4'($urandom);
         channel_mask             = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
         controller_disable       = ($urandom_range(0, 15) == 0);
         if (i % 100 == 0) rotating_priority_config = 1'($urandom);
         if (i % 50 == 0)  autoinit_config = 4'($urandom);
         hlda                     = 1'($urandom);
         underflow                = ($urandom_range(0, 3) == 0);
         eop_n_in                 = ($urandom_range(0, 9) != 0);
         clear_terminal_count     = ($urandom_range(0, 9) == 0);
         master_clear             = ($urandom_range(0, 49) == 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
